// File: rtl/mem_access_sequencer.sv
// Multicycle sequencer between the control unit and the 64-bit data memory:
// one fetch/load/store at a time, byte-lane extraction for loads and RMW for partial stores.
module mem_access_sequencer #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [63:0] mem_addr,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic        wr_q;
    logic [2:0]  size_q;
    logic [2:0]  off_q;
    logic [63:0] wdata_q;
    logic [2:0]  cnt;
    logic        misal, illegal, req_err;

    always_comb begin
        misal = 1'b0;
        case (req_size)
            3'b001, 3'b101: misal = req_addr[0];
            3'b010, 3'b110: misal = |req_addr[1:0];
            3'b011:         misal = |req_addr[2:0];
            default:        misal = 1'b0;
        endcase
        illegal = req_write ? req_size[2] : (req_size == 3'b111);
        req_err = misal | illegal;
    end

    function automatic logic [63:0] load_ext(input logic [63:0] d, input logic [2:0] sz,
                                             input logic [2:0] o);
        logic [63:0] sh;
        sh = d >> {o, 3'b000};
        case (sz)
            3'b000:  load_ext = {{56{sh[7]}}, sh[7:0]};
            3'b001:  load_ext = {{48{sh[15]}}, sh[15:0]};
            3'b010:  load_ext = {{32{sh[31]}}, sh[31:0]};
            3'b100:  load_ext = {56'd0, sh[7:0]};
            3'b101:  load_ext = {48'd0, sh[15:0]};
            3'b110:  load_ext = {32'd0, sh[31:0]};
            default: load_ext = sh;
        endcase
    endfunction

    // Replace bytes o..o+n-1 of the old doubleword with the low n bytes of the store data.
    function automatic logic [63:0] store_merge(input logic [63:0] old, input logic [63:0] w,
                                                input logic [2:0] sz, input logic [2:0] o);
        logic [7:0]  bm;
        logic [63:0] ws;
        case (sz[1:0])
            2'b00:   bm = 8'h01;
            2'b01:   bm = 8'h03;
            2'b10:   bm = 8'h0F;
            default: bm = 8'hFF;
        endcase
        bm = bm << o;
        ws = w << {o, 3'b000};
        store_merge = old;
        for (int i = 0; i < 8; i++)
            if (bm[i]) store_merge[8*i +: 8] = ws[8*i +: 8];
    endfunction

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_wr    = (state == WRITE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            size_q    <= 3'd0;
            off_q     <= 3'd0;
            wdata_q   <= 64'd0;
            cnt       <= 3'd0;
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
            mem_addr  <= 64'd0;
            mem_wdata <= 64'd0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wr_q     <= req_write;
                    size_q   <= req_size;
                    off_q    <= req_addr[2:0];
                    wdata_q  <= req_wdata;
                    mem_addr <= {req_addr[63:3], 3'b000};
                    if (req_err) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 64'd0;
                        state     <= RESP;
                    end else if (req_write && req_size == 3'b011) begin
                        mem_wdata <= req_wdata;
                        state     <= WRITE;
                    end else begin
                        cnt   <= 3'(MEM_LAT);
                        state <= READ;
                    end
                end
                READ: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (wr_q) begin
                            mem_wdata <= store_merge(mem_rdata, wdata_q, size_q, off_q);
                            state     <= WRITE;
                        end else begin
                            rsp_rdata <= load_ext(mem_rdata, size_q, off_q);
                            rsp_err   <= 1'b0;
                            state     <= RESP;
                        end
                    end
                end
                // Response fields only change on the edge entering RESP, so they hold between pulses.
                WRITE: begin
                    rsp_rdata <= 64'd0;
                    rsp_err   <= 1'b0;
                    state     <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
